// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, axis helpers and the registered panel payload
// for the RGB LCD timing generator.
package lcd_timing_pkg;

  localparam int unsigned DEF_CLK_DIV  = 3;
  localparam int unsigned DEF_H_ACTIVE = 480;
  localparam int unsigned DEF_H_FP     = 2;
  localparam int unsigned DEF_H_SYNC   = 41;
  localparam int unsigned DEF_H_BP     = 2;
  localparam int unsigned DEF_V_ACTIVE = 272;
  localparam int unsigned DEF_V_FP     = 2;
  localparam int unsigned DEF_V_SYNC   = 10;
  localparam int unsigned DEF_V_BP     = 2;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total);
    return $clog2(total);
  endfunction

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic    de;
    logic    hsync;
    logic    vsync;
    rgb565_t pix;
  } lcd_out_t;

  // Blanked panel with both syncs idle (high)
  localparam lcd_out_t LCD_OUT_RST = lcd_out_t'({1'b0, 1'b1, 1'b1, 16'h0000});

endpackage

// File: rtl/lcd_axis_counter.sv
// One scan axis: counts 0..TOTAL-1 on inc and decodes the active and sync regions.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int unsigned W     = cnt_width(TOTAL)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Region decode done at 32 bits so boundaries equal to TOTAL never overflow
  assign count  = count_q;
  assign wrap   = (32'(count_q) == TOTAL - 1);
  assign active = (32'(count_q) < ACTIVE);
  assign sync   = (32'(count_q) >= ACTIVE + FP) && (32'(count_q) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/lcd_timing_gen.sv
// Pixel-rate divider, H/V scan and registered panel output stage for the RGB LCD;
// presents x/y to the graphics client and registers its colour answer.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clock,
  input  logic       reset,
  output logic [8:0] x,
  output logic [8:0] y,
  input  logic [4:0] red,
  input  logic [5:0] green,
  input  logic [4:0] blue,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic       lcd_pclk,
  output logic       frame_start
);

  localparam int unsigned DIV_W = cnt_width(CLK_DIV);
  localparam int unsigned H_W   = cnt_width(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned V_W   = cnt_width(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  logic [DIV_W-1:0] div_q, div_d;
  logic             pclk_q, pclk_d;
  lcd_out_t         out_q, out_d;
  logic             pix_en;
  logic             active;

  logic [H_W-1:0] h_count;
  logic           h_wrap, h_active, h_sync;
  logic [V_W-1:0] v_count;
  logic           v_wrap, v_active, v_sync;

  assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));

  // pclk is registered from the next divider value so it stays glitch-free
  always_comb begin
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
    pclk_d = (32'(div_d) >= CLK_DIV / 2);
  end

  lcd_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clock (clock),
    .reset (reset),
    .inc   (pix_en),
    .count (h_count),
    .wrap  (h_wrap),
    .active(h_active),
    .sync  (h_sync)
  );

  lcd_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clock (clock),
    .reset (reset),
    .inc   (pix_en & h_wrap),
    .count (v_count),
    .wrap  (v_wrap),
    .active(v_active),
    .sync  (v_sync)
  );

  assign active = h_active & v_active;

  // Client colour is captured at the end of the pixel window, blanked outside active
  always_comb begin
    out_d = out_q;
    if (pix_en) begin
      out_d.de    = active;
      out_d.hsync = ~h_sync;
      out_d.vsync = ~v_sync;
      out_d.pix.r = active ? red   : '0;
      out_d.pix.g = active ? green : '0;
      out_d.pix.b = active ? blue  : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
      out_q  <= LCD_OUT_RST;
    end else begin
      div_q  <= div_d;
      pclk_q <= pclk_d;
      out_q  <= out_d;
    end
  end

  assign x           = h_active ? 9'(h_count) : '0;
  assign y           = v_active ? 9'(v_count) : '0;
  assign frame_start = pix_en & h_wrap & v_wrap;

  assign lcd_de    = out_q.de;
  assign lcd_hsync = out_q.hsync;
  assign lcd_vsync = out_q.vsync;
  assign lcd_r     = out_q.pix.r;
  assign lcd_g     = out_q.pix.g;
  assign lcd_b     = out_q.pix.b;
  assign lcd_pclk  = pclk_q;

endmodule
